// File: rtl/pid_seq.sv
// -----------------------------------------------------------------------------
// pid_seq -- control-pass sequencer for a shared PID ALU.
//
// One pass (started by go in IDLE) loads the setpoint into Accum, pulses an
// A2D conversion, waits for the result and then walks the ALU through the
// error, integral, I-term, P-term and accumulate steps, ending with a new
// motor command and a one-cycle done pulse.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   go                 : start one pass (ignored while busy)
//   setpt              : unsigned 12-bit setpoint
//   Iterm, Pterm, Fwd  : gain / feed-forward constants (routed to the ALU
//                        outside this block)
//   strt_cnv           : one-cycle A2D start pulse
//   cnv_cmplt          : A2D result valid (only looked at while converting)
//   dst                : ALU result
//   src0sel, src1sel,
//   mult2, mult4, sub,
//   multiply, saturate : ALU control, registered
//   Accum, Pcomp,
//   Error, Intgrl,
//   Icomp              : working registers feeding the ALU operand muxes
//   mtr_cmd            : motor command from the last completed pass
//   busy, done         : pass in progress / pass finished pulse
//
// Build option
//   INTG_DECIM_EN      : when defined, Intgrl is only updated on every fourth
//                        pass (2-bit pass counter); state timing is unchanged.
// -----------------------------------------------------------------------------
module pid_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [11:0] setpt,
    input  logic [11:0] Iterm,
    input  logic [13:0] Pterm,
    input  logic [11:0] Fwd,
    output logic        strt_cnv,
    input  logic        cnv_cmplt,
    input  logic [15:0] dst,
    output logic [2:0]  src0sel,
    output logic [2:0]  src1sel,
    output logic        mult2,
    output logic        mult4,
    output logic        sub,
    output logic        multiply,
    output logic        saturate,
    output logic [15:0] Accum,
    output logic [15:0] Pcomp,
    output logic [11:0] Error,
    output logic [11:0] Intgrl,
    output logic [11:0] Icomp,
    output logic [11:0] mtr_cmd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CNV   = 4'd1,
        ERR   = 4'd2,
        INTG  = 4'd3,
        ICMP1 = 4'd4,
        ICMP2 = 4'd5,
        PCMP1 = 4'd6,
        PCMP2 = 4'd7,
        ACC1  = 4'd8,
        ACC2  = 4'd9
    } state_t;

    typedef struct packed {
        logic [2:0] src1sel;
        logic [2:0] src0sel;
        logic       sub;
        logic       multiply;
        logic       saturate;
    } ctrl_t;

    state_t state_r;
    ctrl_t  ctrl_r;

`ifdef INTG_DECIM_EN
    logic [1:0] pass_cnt_r;
`endif

    // ALU control word that must be presented while sitting in state s.
    // Registering ctrl_of(next_state) makes the controls line up with the state.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ERR: begin
                c.src1sel  = 3'b000;
                c.src0sel  = 3'b000;
                c.sub      = 1'b1;
                c.saturate = 1'b1;
            end
            INTG: begin
                c.src1sel  = 3'b011;
                c.src0sel  = 3'b001;
                c.saturate = 1'b1;
            end
            ICMP1, ICMP2: begin
                c.src1sel  = 3'b001;
                c.src0sel  = 3'b001;
                c.multiply = 1'b1;
            end
            PCMP1, PCMP2: begin
                c.src1sel  = 3'b010;
                c.src0sel  = 3'b100;
                c.multiply = 1'b1;
            end
            ACC1: begin
                c.src1sel  = 3'b100;
                c.src0sel  = 3'b011;
            end
            ACC2: begin
                c.src1sel  = 3'b000;
                c.src0sel  = 3'b010;
                c.saturate = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequencer: state, registered controls and working registers.
    // Each register is written only on exit from the state that produces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ctrl_r   <= '0;
            Accum    <= 16'd0;
            Pcomp    <= 16'd0;
            Error    <= 12'd0;
            Intgrl   <= 12'd0;
            Icomp    <= 12'd0;
            mtr_cmd  <= 12'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            strt_cnv <= 1'b0;
`ifdef INTG_DECIM_EN
            pass_cnt_r <= 2'd0;
`endif
        end else begin
            strt_cnv <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (go) begin
                        Accum    <= {4'h0, setpt};
                        strt_cnv <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= CNV;
                        ctrl_r   <= ctrl_of(CNV);
                    end else begin
                        ctrl_r   <= ctrl_of(IDLE);
                    end
                end
                CNV: begin
                    if (cnv_cmplt) begin
                        state_r <= ERR;
                        ctrl_r  <= ctrl_of(ERR);
                    end else begin
                        ctrl_r  <= ctrl_of(CNV);
                    end
                end
                ERR: begin
                    Error   <= dst[11:0];
                    state_r <= INTG;
                    ctrl_r  <= ctrl_of(INTG);
                end
                INTG: begin
`ifdef INTG_DECIM_EN
                    if (pass_cnt_r == 2'd3) begin
                        Intgrl <= dst[11:0];
                    end else begin
                        Intgrl <= Intgrl;
                    end
`else
                    Intgrl  <= dst[11:0];
`endif
                    state_r <= ICMP1;
                    ctrl_r  <= ctrl_of(ICMP1);
                end
                ICMP1: begin
                    // multiplier result is only trusted after the second cycle
                    state_r <= ICMP2;
                    ctrl_r  <= ctrl_of(ICMP2);
                end
                ICMP2: begin
                    Icomp   <= dst[11:0];
                    state_r <= PCMP1;
                    ctrl_r  <= ctrl_of(PCMP1);
                end
                PCMP1: begin
                    state_r <= PCMP2;
                    ctrl_r  <= ctrl_of(PCMP2);
                end
                PCMP2: begin
                    Pcomp   <= dst;
                    state_r <= ACC1;
                    ctrl_r  <= ctrl_of(ACC1);
                end
                ACC1: begin
                    Accum   <= dst;
                    state_r <= ACC2;
                    ctrl_r  <= ctrl_of(ACC2);
                end
                ACC2: begin
                    Accum   <= dst;
                    mtr_cmd <= dst[11:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                    ctrl_r  <= ctrl_of(IDLE);
`ifdef INTG_DECIM_EN
                    pass_cnt_r <= pass_cnt_r + 2'd1;
`endif
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                    ctrl_r  <= '0;
                end
            endcase
        end
    end

    assign src1sel  = ctrl_r.src1sel;
    assign src0sel  = ctrl_r.src0sel;
    assign sub      = ctrl_r.sub;
    assign multiply = ctrl_r.multiply;
    assign saturate = ctrl_r.saturate;
    assign mult2    = 1'b0;
    assign mult4    = 1'b0;

    // The gain constants reach the ALU outside this block; they are reduced
    // here only so that the unused inputs are visibly accounted for.
    logic unused_consts_s;
    assign unused_consts_s = &{1'b0, Iterm, Pterm, Fwd};

endmodule

// File: tb/tb_pid_seq.sv
module tb_pid_seq;

    logic        clk = 1'b0;
    logic        rst, go, cnv_cmplt;
    logic [11:0] setpt, Iterm, Fwd;
    logic [13:0] Pterm;
    logic [15:0] dst;
    logic        strt_cnv;
    logic [2:0]  src0sel, src1sel;
    logic        mult2, mult4, sub, multiply, saturate;
    logic [15:0] Accum, Pcomp;
    logic [11:0] Error, Intgrl, Icomp, mtr_cmd;
    logic        busy, done;
    logic [11:0] a2d_val;

    int checks = 0;
    int errors = 0;

    // reference-model state (plain integers)
    int intg_m = 0;
    int pass_cnt_m = 0;
    int err_m, icomp_m, pcomp_m, acc1_m, mtr_m;

    pid_seq dut (
        .clk(clk), .rst(rst), .go(go), .setpt(setpt), .Iterm(Iterm),
        .Pterm(Pterm), .Fwd(Fwd), .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt),
        .dst(dst), .src0sel(src0sel), .src1sel(src1sel), .mult2(mult2),
        .mult4(mult4), .sub(sub), .multiply(multiply), .saturate(saturate),
        .Accum(Accum), .Pcomp(Pcomp), .Error(Error), .Intgrl(Intgrl),
        .Icomp(Icomp), .mtr_cmd(mtr_cmd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int sx12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic int sx16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Environment ALU: operands chosen by the DUT's select lines.
    function automatic logic [15:0] alu_f(
        input logic [2:0] s1sel, input logic [2:0] s0sel,
        input logic sb, input logic mul, input logic sat);
        int s1, s0, r;
        case (s1sel)
            3'b000:  s1 = sx16(Accum);
            3'b001:  s1 = {20'd0, Iterm};
            3'b010:  s1 = sx12(Error);
            3'b011:  s1 = sx12(Error) >>> 4;
            3'b100:  s1 = {20'd0, Fwd};
            default: s1 = 0;
        endcase
        case (s0sel)
            3'b000:  s0 = {20'd0, a2d_val};
            3'b001:  s0 = sx12(Intgrl);
            3'b010:  s0 = sx12(Icomp);
            3'b011:  s0 = sx16(Pcomp);
            3'b100:  s0 = {18'd0, Pterm};
            default: s0 = 0;
        endcase
        if (mul) begin
            r = (s1 * s0) >>> 12;
        end else begin
            r = sb ? (s1 - s0) : (s1 + s0);
            if (sat) r = sat12(r);
        end
        return r[15:0];
    endfunction

    always_comb dst = alu_f(src1sel, src0sel, sub, multiply, saturate);

    // Expected {src1sel,src0sel,sub,multiply,saturate} n cycles after cnv_cmplt.
    function automatic logic [8:0] exp_ctrl(input int n);
        case (n)
            1:       return {3'b000, 3'b000, 1'b1, 1'b0, 1'b1};
            2:       return {3'b011, 3'b001, 1'b0, 1'b0, 1'b1};
            3, 4:    return {3'b001, 3'b001, 1'b0, 1'b1, 1'b0};
            5, 6:    return {3'b010, 3'b100, 1'b0, 1'b1, 1'b0};
            7:       return {3'b100, 3'b011, 1'b0, 1'b0, 1'b0};
            8:       return {3'b000, 3'b010, 1'b0, 1'b0, 1'b1};
            default: return 9'd0;
        endcase
    endfunction

    // Reference model of one complete pass.
    task automatic model_pass(input logic [11:0] sp, input logic [11:0] it,
                              input logic [13:0] pt, input logic [11:0] fw,
                              input logic [11:0] a2d);
        err_m = sat12(int'({20'd0, sp}) - int'({20'd0, a2d}));
`ifdef INTG_DECIM_EN
        if (pass_cnt_m == 3) intg_m = sat12((err_m >>> 4) + intg_m);
`else
        intg_m = sat12((err_m >>> 4) + intg_m);
`endif
        pass_cnt_m = (pass_cnt_m + 1) % 4;
        icomp_m = (int'({20'd0, it}) * intg_m) >>> 12;
        pcomp_m = (err_m * int'({18'd0, pt})) >>> 12;
        acc1_m  = int'({20'd0, fw}) + pcomp_m;
        mtr_m   = sat12(acc1_m + icomp_m);
    endtask

    // One pass. pre=1: DUT was already started (back-to-back); go_at: cycle
    // (after cnv_cmplt) in which go is pulsed; rst_at: cycle to assert rst.
    task automatic run_pass(input logic [11:0] sp, input logic [11:0] it,
                            input logic [13:0] pt, input logic [11:0] fw,
                            input logic [11:0] a2d, input int stall,
                            input int go_at, input int rst_at, input bit pre);
        int done_n, done_cnt, starts, exp_starts;
        logic [11:0] err_before;
        logic [15:0] exp_acc;
        setpt = sp; Iterm = it; Pterm = pt; Fwd = fw; a2d_val = a2d;
        if (!pre) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            checks++;
            if ({strt_cnv, busy} !== 2'b11) begin
                errors++;
                $display("FAIL start: strt_cnv,busy got %b expected 11", {strt_cnv, busy});
            end
            checks++;
            if (Accum !== {4'h0, sp}) begin
                errors++;
                $display("FAIL accum_load: got %h expected %h", Accum, {4'h0, sp});
            end
        end
        err_before = Error;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checks++;
            if ({strt_cnv, src1sel, src0sel, sub, multiply, saturate, busy} !== 11'b00000000001
                || Error !== err_before) begin
                errors++;
                $display("FAIL stall_cnv: ctrl %b err %h expected 0/busy err %h",
                         {strt_cnv, src1sel, src0sel, sub, multiply, saturate, busy}, Error, err_before);
            end
        end
        cnv_cmplt = 1'b1;
        done_n = 0; done_cnt = 0; starts = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            go = (n == go_at) ? 1'b1 : 1'b0;
            if (strt_cnv) starts++;
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (n <= 8 && (rst_at == 0 || n <= rst_at)) begin
                checks++;
                if ({src1sel, src0sel, sub, multiply, saturate, mult2, mult4, busy}
                    !== {exp_ctrl(n), 3'b001}) begin
                    errors++;
                    $display("FAIL ctrl_step%0d: got %b expected %b", n,
                             {src1sel, src0sel, sub, multiply, saturate, mult2, mult4, busy},
                             {exp_ctrl(n), 3'b001});
                end
            end
            if (rst_at != 0 && n == rst_at) rst = 1'b1;
            if (rst_at != 0 && n == rst_at + 1) begin
                rst = 1'b0;
                checks++;
                if ({Accum, Pcomp, Error, Intgrl, Icomp, mtr_cmd, busy, done, strt_cnv,
                     src0sel, src1sel, mult2, mult4, sub, multiply, saturate} !== 99'd0) begin
                    errors++;
                    $display("FAIL midpass_reset: outputs not zero acc %h err %h intg %h busy %b",
                             Accum, Error, Intgrl, busy);
                end
            end
        end
        go = 1'b0;
        if (rst_at != 0) begin
            intg_m = 0; pass_cnt_m = 0;
            checks++;
            if (done_cnt != 0 || starts != 0) begin
                errors++;
                $display("FAIL reset_abort: done %0d starts %0d expected 0 0", done_cnt, starts);
            end
            return;
        end
        model_pass(sp, it, pt, fw, a2d);
        exp_starts = (go_at == 9) ? 1 : 0;
        exp_acc = (go_at == 9) ? {4'h0, sp} : mtr_m[15:0];
        checks++;
        if (done_n != 9 || done_cnt != 1) begin
            errors++;
            $display("FAIL done_timing: at %0d count %0d expected 9 1", done_n, done_cnt);
        end
        checks++;
        if (starts != exp_starts) begin
            errors++;
            $display("FAIL extra_start: got %0d expected %0d", starts, exp_starts);
        end
        checks++;
        if (Error !== err_m[11:0]) begin
            errors++;
            $display("FAIL error_reg: got %h expected %h", Error, err_m[11:0]);
        end
        checks++;
        if (Intgrl !== intg_m[11:0]) begin
            errors++;
            $display("FAIL intgrl_reg: got %h expected %h", Intgrl, intg_m[11:0]);
        end
        checks++;
        if (Icomp !== icomp_m[11:0] || Pcomp !== pcomp_m[15:0]) begin
            errors++;
            $display("FAIL comp_regs: icomp %h pcomp %h expected %h %h",
                     Icomp, Pcomp, icomp_m[11:0], pcomp_m[15:0]);
        end
        checks++;
        if (mtr_cmd !== mtr_m[11:0] || Accum !== exp_acc) begin
            errors++;
            $display("FAIL mtr_cmd: mtr %h acc %h expected %h %h",
                     mtr_cmd, Accum, mtr_m[11:0], exp_acc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        intg_m = 0; pass_cnt_m = 0;
    endtask

    task automatic test_reset();
        go = 1'b0; cnv_cmplt = 1'b0; setpt = 12'd0; Iterm = 12'd0;
        Pterm = 14'd0; Fwd = 12'd0; a2d_val = 12'd0;
        do_reset();
        checks++;
        if ({Accum, Pcomp, Error, Intgrl, Icomp, mtr_cmd, busy, done, strt_cnv,
             src0sel, src1sel, mult2, mult4, sub, multiply, saturate} !== 99'd0) begin
            errors++;
            $display("FAIL reset_state: acc %h err %h intg %h busy %b ctrl %b",
                     Accum, Error, Intgrl, busy, {src1sel, src0sel, sub, multiply, saturate});
        end
    endtask

    task automatic test_nominal();
        run_pass(12'h400, 12'h800, 14'h1000, 12'h200, 12'h300, 0, 0, 0, 1'b0);
        checks++;
        if (Error !== 12'h100 || Pcomp !== 16'h0100) begin
            errors++;
            $display("FAIL nominal_err_p: err %h pcomp %h expected 100 0100", Error, Pcomp);
        end
`ifndef INTG_DECIM_EN
        checks++;
        if (Intgrl !== 12'h010 || Icomp !== 12'h008 || mtr_cmd !== 12'h308) begin
            errors++;
            $display("FAIL nominal_out: intg %h icomp %h mtr %h expected 010 008 308",
                     Intgrl, Icomp, mtr_cmd);
        end
        run_pass(12'h400, 12'h800, 14'h1000, 12'h200, 12'h300, 0, 0, 0, 1'b0);
        checks++;
        if (Intgrl !== 12'h020) begin
            errors++;
            $display("FAIL intgrl_persist: got %h expected 020", Intgrl);
        end
`endif
    endtask

    task automatic test_error_sat();
        run_pass(12'h000, 12'h123, 14'h0456, 12'h010, 12'hFFF, 0, 0, 0, 1'b0);
        checks++;
        if (Error !== 12'h800) begin
            errors++;
            $display("FAIL error_sat: got %h expected 800", Error);
        end
    endtask

    task automatic test_busy_lockout();
        run_pass(12'h345, 12'h200, 14'h0800, 12'h100, 12'h300, 0, 5, 0, 1'b0);
    endtask

    task automatic test_a2d_stall();
        run_pass(12'h500, 12'h400, 14'h2000, 12'h050, 12'h280, 50, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        run_pass(12'h600, 12'h400, 14'h1000, 12'h050, 12'h100, 2, 0, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_pass(12'h700, 12'h300, 14'h0C00, 12'h020, 12'h350, 0, 9, 0, 1'b0);
        run_pass(12'h700, 12'h300, 14'h0C00, 12'h020, 12'h6A0, 1, 0, 0, 1'b1);
    endtask

`ifdef INTG_DECIM_EN
    task automatic test_decim();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            run_pass(12'h400, 12'h800, 14'h1000, 12'h200, 12'h300, 0, 0, 0, 1'b0);
            checks++;
            if (Intgrl !== ((p == 3) ? 12'h010 : 12'h000)) begin
                errors++;
                $display("FAIL decim_pass%0d: got %h expected %h", p + 1, Intgrl,
                         (p == 3) ? 12'h010 : 12'h000);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_pass(12'($urandom), 12'($urandom), 14'($urandom), 12'($urandom),
                     12'($urandom), int'($urandom_range(0, 5)), 0, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_error_sat();
        test_busy_lockout();
        test_a2d_stall();
        test_reset_mid_pass();
        test_back_to_back();
`ifdef INTG_DECIM_EN
        test_decim();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
